// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, requester slots, defaults.
package echo_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_RDY = 2'd1,
      STROBE   = 2'd2,
      WAIT_ACK = 2'd3
   } arb_state_e;

   localparam int REQ_SCAN   = 0;
   localparam int REQ_STATUS = 1;
   localparam int REQ_ECHO   = 2;
   localparam int REQ_DEBUG  = 3;

   localparam int NREQ_DEFAULT        = 4;
   localparam int ACK_TIMEOUT_DEFAULT = 16;

   // Round-robin successor of a requester index.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1) % n;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the transmitter write port, as seen by the arbiter.
interface uart_tx_arbiter_if
   import echo_pkg::*;
#(
   parameter int NREQ = NREQ_DEFAULT
);
   logic [NREQ-1:0]   req_valid;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   req_last;
   logic [NREQ-1:0]   req_ready;
   logic              tx_rdy;
   logic              data_wen;
   logic [7:0]        data;

   modport master (
      input  req_valid, req_data, req_last, tx_rdy,
      output req_ready, data_wen, data
   );

   modport slave (
      output req_valid, req_data, req_last, tx_rdy,
      input  req_ready, data_wen, data
   );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Rotating-priority search: first set request at or above start_i, wrapping modulo N.
module rr_pick #(
   parameter int N = 4,
   parameter int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] start_i,
   output logic         found_o,
   output logic [W-1:0] idx_o
);
   logic [W-1:0] cand;

   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
      found_o = 1'b0;
      idx_o   = '0;
      cand    = '0;
      // Walk from the farthest candidate down so the nearest one to start_i wins last.
      for (int k = N - 1; k >= 0; k--) begin
         cand = W'((int'(start_i) + k) % N);
         if (req_i[cand]) begin
            found_o = 1'b1;
            idx_o   = cand;
         end
      end
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin frame arbiter in front of a single UART transmitter write port.
// A granted requester keeps the transmitter until its byte flagged last has been accepted.
module uart_tx_arbiter
   import echo_pkg::*;
#(
   parameter int NREQ        = NREQ_DEFAULT,
   parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst_n,
   uart_tx_arbiter_if.master       bus,
   output logic [$clog2(NREQ)-1:0] grant_id_o,
   output logic                    busy_o,
   output logic                    timeout_err_o
);
   localparam int IDW = $clog2(NREQ);
   localparam int TW  = $clog2(ACK_TIMEOUT + 1);

   arb_state_e      state_q;
   logic [IDW-1:0]  rr_ptr_q;
   logic [IDW-1:0]  grant_id_q;
   logic [TW-1:0]   timer_q;
   logic [TW-1:0]   timer_d;
   logic            is_last_q;
   logic            busy_q;
   logic            timeout_err_q;
   logic            data_wen_q;
   logic [7:0]      data_q;
   logic [NREQ-1:0] req_ready_q;

   logic            pick_found;
   logic [IDW-1:0]  pick_idx;
   logic            owner_valid;
   logic            owner_last;
   logic [7:0]      owner_data;
   logic            ack_timeout;
   logic            ack_done;

   rr_pick #(.N(NREQ), .W(IDW)) u_rr_pick (
      .req_i   (bus.req_valid),
      .start_i (rr_ptr_q),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   assign owner_valid = bus.req_valid[grant_id_q];
   assign owner_last  = bus.req_last[grant_id_q];
   assign owner_data  = bus.req_data[{grant_id_q, 3'b000} +: 8];

   // The timer counts tx_rdy-high cycles after the strobe; reaching ACK_TIMEOUT-1 gives up waiting.
   assign timer_d     = timer_q + 1'b1;
   assign ack_timeout = bus.tx_rdy && (timer_d == TW'(ACK_TIMEOUT - 1));
   assign ack_done    = !bus.tx_rdy || ack_timeout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         rr_ptr_q      <= '0;
         grant_id_q    <= '0;
         timer_q       <= '0;
         is_last_q     <= 1'b0;
         busy_q        <= 1'b0;
         timeout_err_q <= 1'b0;
         data_wen_q    <= 1'b1;
         data_q        <= '0;
         req_ready_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments only, so every branch reads the pre-edge register values.
         req_ready_q   <= '0;
         data_wen_q    <= 1'b1;
         timeout_err_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (pick_found) begin
                  grant_id_q <= pick_idx;
                  busy_q     <= 1'b1;
                  state_q    <= WAIT_RDY;
               end
            end
            WAIT_RDY: begin
               // A gap in the owner's stream simply holds the lock here.
               if (bus.tx_rdy && owner_valid) begin
                  data_q                  <= owner_data;
                  data_wen_q              <= 1'b0;
                  req_ready_q[grant_id_q] <= 1'b1;
                  is_last_q               <= owner_last;
                  state_q                 <= STROBE;
               end
            end
            STROBE: begin
               timer_q <= '0;
               state_q <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (bus.tx_rdy) timer_q <= timer_d;
               timeout_err_q <= ack_timeout;
               if (ack_done) begin
                  if (is_last_q) begin
                     rr_ptr_q <= IDW'(rr_next(int'(grant_id_q), NREQ));
                     busy_q   <= 1'b0;
                     state_q  <= IDLE;
                  end else begin
                     state_q  <= WAIT_RDY;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.data_wen   = data_wen_q;
   assign bus.data       = data_q;
   assign grant_id_o     = grant_id_q;
   assign busy_o         = busy_q;
   assign timeout_err_o  = timeout_err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: requester and transmitter models, a frame-level
// round-robin reference, a table of arbitration vectors and directed corner sequences.
module tb_uart_tx_arbiter;
   import echo_pkg::*;

   localparam int N  = 4;
   localparam int TO = 16;

   typedef struct {logic [7:0] d; logic last;} rbyte_t;
   typedef struct {int id; logic [7:0] d;} exp_t;
   typedef struct {int prev; logic [N-1:0] mask; int exp_grant;} vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] grant_id;
   logic       busy;
   logic       timeout_err;

   uart_tx_arbiter_if #(.NREQ(N)) bus ();

   uart_tx_arbiter #(.NREQ(N), .ACK_TIMEOUT(TO)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .bus           (bus),
      .grant_id_o    (grant_id),
      .busy_o        (busy),
      .timeout_err_o (timeout_err)
   );

   always #5 clk = ~clk;

   rbyte_t q[N][$];
   rbyte_t rq[N][$];
   exp_t   exp_q[$];
   int     gap[N];
   bit     gap_en = 1'b0;

   int total = 0;
   int bad   = 0;
   int cyc = 0, n_strobe = 0, to_count = 0, last_strobe_cyc = 0;
   int rr_pulses[N];

   int tx_drop_delay = 2, tx_low_len = 2, pend = 0, low_cnt = 0;
   bit tx_hold = 1'b0;

   assign bus.tx_rdy = !(tx_hold || (low_cnt != 0));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Requester model: offers queued bytes, advances on req_ready, optional gaps inside frames.
   initial begin : requester_model
      rbyte_t rb;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.req_last  = '0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (!rst_n) gap[i] = 0;
            else if (bus.req_ready[i] && q[i].size() > 0) begin
               rb = q[i].pop_front();
               if (!rb.last && gap_en) gap[i] = int'($urandom_range(0, 2));
            end
            if (gap[i] > 0) begin
               gap[i]--;
               bus.req_valid[i] = 1'b0;
            end else if (q[i].size() > 0) begin
               bus.req_valid[i]       = 1'b1;
               bus.req_data[8*i +: 8] = q[i][0].d;
               bus.req_last[i]        = q[i][0].last;
            end else begin
               bus.req_valid[i] = 1'b0;
            end
         end
      end
   end

   // Transmitter model: tx_rdy falls tx_drop_delay cycles after a strobe (never if 0).
   initial begin : tx_model
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pend = 0;
            low_cnt = 0;
         end else if (!bus.data_wen) pend = tx_drop_delay;
         else if (pend > 0) begin
            pend--;
            if (pend == 0) low_cnt = tx_low_len;
         end else if (low_cnt > 0) low_cnt--;
      end
   end

   // Monitor: every strobe is matched against the next expected {owner, byte}.
   initial begin : monitor
      exp_t         e;
      logic [N-1:0] oh;
      bit           prev_wen;
      prev_wen = 1'b1;
      for (int i = 0; i < N; i++) rr_pulses[i] = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst_n) begin
            for (int i = 0; i < N; i++) if (bus.req_ready[i]) rr_pulses[i]++;
            if (timeout_err) begin
               to_count++;
               check("timeout_delay", cyc - last_strobe_cyc, TO);
            end
            if (!bus.data_wen) begin
               n_strobe++;
               last_strobe_cyc = cyc;
               check("wen_one_cycle", prev_wen, 1);
               check("strobe_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  oh = '0;
                  oh[e.id] = 1'b1;
                  check("strobe_data", bus.data, e.d);
                  check("strobe_owner", grant_id, e.id);
                  check("strobe_ready", bus.req_ready, oh);
                  check("strobe_busy", busy, 1);
               end
            end
         end
         prev_wen = bus.data_wen;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic do_reset();
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      for (int i = 0; i < N; i++) q[i].delete();
      exp_q.delete();
      tx_hold = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({name, "_done"}, n < 3000, 1);
   endtask

   task automatic wait_strobes(input string name, input int target);
      int n;
      n = 0;
      while (n_strobe < target && n < 500) begin
         @(negedge clk);
         n++;
      end
      check({name, "_strobe_seen"}, n < 500, 1);
   endtask

   task automatic push_q(input int id, input logic [7:0] d, input logic last);
      rbyte_t rb;
      rb.d = d;
      rb.last = last;
      q[id].push_back(rb);
   endtask

   task automatic push_exp(input int id, input logic [7:0] d);
      exp_t e;
      e.id = id;
      e.d = d;
      exp_q.push_back(e);
   endtask

   initial begin : main
      vec_t vt[8];
      int   n0, r0, t0, n, nf, len, p, found;
      rbyte_t rb;

      vt[0] = '{-1, 4'b0110, 1};
      vt[1] = '{-1, 4'b1000, 3};
      vt[2] = '{ 0, 4'b0001, 0};
      vt[3] = '{ 1, 4'b0011, 0};
      vt[4] = '{ 2, 4'b1111, 3};
      vt[5] = '{ 3, 4'b1110, 1};
      vt[6] = '{ 3, 4'b1001, 0};
      vt[7] = '{ 2, 4'b0110, 1};

      repeat (3) @(negedge clk);
      check("rst_data_wen", bus.data_wen, 1);
      check("rst_data", bus.data, 0);
      check("rst_req_ready", bus.req_ready, 0);
      check("rst_grant", grant_id, 0);
      check("rst_busy", busy, 0);
      check("rst_timeout", timeout_err, 0);
      #1;
      rst_n = 1'b1;

      // Single requester, two-byte frame; then rr_ptr=1 must favour requester 1 over 0.
      n0 = n_strobe;
      r0 = rr_pulses[0];
      push_q(REQ_SCAN, 8'h12, 1'b0);
      push_q(REQ_SCAN, 8'h35, 1'b1);
      push_exp(0, 8'h12);
      push_exp(0, 8'h35);
      wait_idle("t1");
      check("t1_strobes", n_strobe - n0, 2);
      check("t1_ready0", rr_pulses[0] - r0, 2);
      check("t1_grant_hold", grant_id, 0);
      check("t1_busy_off", busy, 0);
      push_exp(1, 8'hA1);
      push_exp(0, 8'hA0);
      push_q(0, 8'hA0, 1'b1);
      push_q(1, 8'hA1, 1'b1);
      wait_idle("t1_ptr");

      // Simultaneous requesters 1 and 2 from reset: all of frame 1 before frame 2.
      do_reset();
      push_exp(1, 8'h21);
      push_exp(1, 8'h22);
      push_exp(2, 8'h31);
      push_exp(2, 8'h32);
      push_q(1, 8'h21, 1'b0);
      push_q(1, 8'h22, 1'b1);
      push_q(2, 8'h31, 1'b0);
      push_q(2, 8'h32, 1'b1);
      wait_idle("t2");
      check("t2_grant_last", grant_id, 2);

      // Requester 0 streams frames; requester 3 joins mid-frame and goes next.
      do_reset();
      n0 = n_strobe;
      push_exp(0, 8'h01); push_exp(0, 8'h02); push_exp(3, 8'h3A);
      push_exp(0, 8'h03); push_exp(0, 8'h04); push_exp(0, 8'h05); push_exp(0, 8'h06);
      push_q(0, 8'h01, 1'b0); push_q(0, 8'h02, 1'b1);
      push_q(0, 8'h03, 1'b0); push_q(0, 8'h04, 1'b1);
      push_q(0, 8'h05, 1'b0); push_q(0, 8'h06, 1'b1);
      wait_strobes("t3", n0 + 1);
      push_q(3, 8'h3A, 1'b1);
      wait_idle("t3");

      // Transmitter never acknowledges: one timeout per byte, frame still completes.
      do_reset();
      tx_drop_delay = 0;
      t0 = to_count;
      push_exp(2, 8'h5A);
      push_exp(2, 8'hA5);
      push_q(2, 8'h5A, 1'b0);
      push_q(2, 8'hA5, 1'b1);
      wait_idle("t4");
      check("t4_timeouts", to_count - t0, 2);
      tx_drop_delay = 2;

      // Transmitter busy at request time: no strobe until tx_rdy rises, then the very next cycle.
      do_reset();
      tx_hold = 1'b1;
      n0 = n_strobe;
      push_exp(2, 8'h77);
      push_q(2, 8'h77, 1'b1);
      repeat (10) @(negedge clk);
      check("t5_no_strobe", n_strobe - n0, 0);
      check("t5_wen_high", bus.data_wen, 1);
      check("t5_locked", busy, 1);
      check("t5_owner", grant_id, 2);
      #1;
      tx_hold = 1'b0;
      @(negedge clk);
      check("t5_strobe_next", bus.data_wen, 0);
      check("t5_strobe_data", bus.data, 8'h77);
      wait_idle("t5");

      // Reset in the middle of a 3-byte frame; afterwards arbitration restarts at rr_ptr=0.
      do_reset();
      tx_drop_delay = 1;
      tx_low_len = 1;
      push_exp(2, 8'hC2);
      push_q(2, 8'hC2, 1'b1);
      wait_idle("t6_pre");
      n0 = n_strobe;
      push_exp(3, 8'hD1);
      push_q(3, 8'hD1, 1'b0);
      push_q(3, 8'hD2, 1'b0);
      push_q(3, 8'hD3, 1'b1);
      wait_strobes("t6", n0 + 1);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("t6_rst_wen", bus.data_wen, 1);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_ready", bus.req_ready, 0);
      for (int i = 0; i < N; i++) q[i].delete();
      exp_q.delete();
      repeat (2) @(negedge clk);
      push_exp(1, 8'hB1);
      push_exp(3, 8'hB3);
      push_q(1, 8'hB1, 1'b1);
      push_q(3, 8'hB3, 1'b1);
      #1;
      rst_n = 1'b1;
      wait_idle("t6_post");
      tx_drop_delay = 2;
      tx_low_len = 2;

      // Arbitration vectors: optional previous owner sets rr_ptr, then a request mask.
      for (int v = 0; v < 8; v++) begin
         do_reset();
         if (vt[v].prev >= 0) begin
            push_exp(vt[v].prev, 8'(8'h40 + vt[v].prev));
            push_q(vt[v].prev, 8'(8'h40 + vt[v].prev), 1'b1);
            wait_idle("tab_prev");
         end
         push_exp(vt[v].exp_grant, 8'(8'h50 + vt[v].exp_grant));
         for (int i = 0; i < N; i++) if (vt[v].mask[i]) push_q(i, 8'(8'h50 + i), 1'b1);
         n = 0;
         while (!busy && n < 50) begin
            @(negedge clk);
            n++;
         end
         check("tab_busy", busy, 1);
         check("tab_grant", grant_id, vt[v].exp_grant);
         n = 0;
         while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
         end
         check("tab_first_strobe", n < 200, 1);
      end

      // Randomized frames against a frame-level round-robin reference.
      for (int r = 0; r < 4; r++) begin
         do_reset();
         gap_en = 1'b1;
         tx_drop_delay = int'($urandom_range(1, 4));
         tx_low_len = int'($urandom_range(1, 3));
         t0 = to_count;
         for (int i = 0; i < N; i++) begin
            rq[i].delete();
            nf = int'($urandom_range(0, 3));
            for (int f = 0; f < nf; f++) begin
               len = int'($urandom_range(1, 4));
               for (int b = 0; b < len; b++) begin
                  rb.d = 8'($urandom);
                  rb.last = (b == len - 1);
                  q[i].push_back(rb);
                  rq[i].push_back(rb);
               end
            end
         end
         p = 0;
         forever begin
            found = -1;
            for (int k = 0; k < N; k++)
               if (found < 0 && rq[(p + k) % N].size() > 0) found = (p + k) % N;
            if (found < 0) break;
            do begin
               rb = rq[found].pop_front();
               push_exp(found, rb.d);
            end while (!rb.last);
            p = (found + 1) % N;
         end
         wait_idle("rand");
         check("rand_no_timeout", to_count - t0, 0);
         n = 0;
         for (int i = 0; i < N; i++) n += q[i].size();
         check("rand_drained", n, 0);
      end
      gap_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter among NREQ byte-stream requesters: the scan reporter (distance/angle pairs), status/echo reporter, and debug sources.
Grants whole frames in round-robin order and never interleaves bytes of different frames.
Drives the transmitter's write interface: active-low one-cycle data_wen strobe, with tx_rdy high meaning idle.
Sits between the control logic and the UART transmitter.

Parameters:
NREQ, 4, number of requesters (2..8)
ACK_TIMEOUT, 16, cycles to wait for tx_rdy to fall after a strobe before declaring the byte accepted and flagging an error

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  NREQ  requester i has a byte on req_data slice i
req_data  in  8*NREQ  byte from requester i, bits [8i+7:8i]; held stable while req_valid[i]=1
req_last  in  NREQ  the offered byte is the final byte of requester i's frame
req_ready  out  NREQ  one-cycle pulse: requester i's byte taken this cycle
tx_rdy  in  1  transmitter idle/ready (high = can accept)
data_wen  out  1  active-low write strobe to transmitter, low exactly one cycle per byte
data  out  8  byte to transmitter, valid while data_wen=0, then held
grant_id  out  clog2(NREQ)  current or last frame owner
busy  out  1  high while a frame owner is locked
timeout_err  out  1  one-cycle pulse when ACK_TIMEOUT expires

Behaviour:
- Reset values: data_wen=1, data=0, req_ready=0, grant_id=0, busy=0, timeout_err=0. Internal: rr_ptr=0, state=IDLE, timer=0. Reset mid-frame aborts the frame silently; no strobe is emitted after reset.
- All outputs are registered.
- IDLE:
  - If any req_valid, owner = first i with req_valid[i], searched from rr_ptr upward with wrap modulo NREQ.
  - Latch grant_id=owner, busy=1, go to WAIT_RDY.
  - Arbitration costs one cycle.
- WAIT_RDY:
  - If tx_rdy=1 and req_valid[owner]=1: data=req_data[owner], data_wen=0, req_ready[owner]=1, latch is_last=req_last[owner], go to STROBE.
  - Otherwise stay. A mid-frame gap with req_valid low keeps the lock; other requesters wait.
- STROBE: data_wen=1, req_ready=0, timer=0, go to WAIT_ACK.
- WAIT_ACK:
  - If tx_rdy=0, the byte is accepted.
  - Else timer++. When timer reaches ACK_TIMEOUT-1: timeout_err=1 for one cycle, byte treated as accepted.
  - On acceptance:
    - If is_last: rr_ptr=(owner+1) mod NREQ, busy=0, go to IDLE.
    - Else go to WAIT_RDY.
- Minimum byte period is 4 cycles plus transmitter time. Back-to-back frames from different requesters are separated by one IDLE cycle.
- Simultaneous requests resolve by rotating priority. Every requester is served within NREQ-1 frames of other requesters (starvation-free).
- A single-byte frame is one byte with req_last=1.
- req_valid dropping without req_ready is legal only between bytes. The arbiter never samples req_data except in the WAIT_RDY accept cycle.
- grant_id holds its value after the frame ends.

Decomposition:
- Shared package echo_pkg:
  - Arbiter state encoding (IDLE, WAIT_RDY, STROBE, WAIT_ACK).
  - Requester index constants: REQ_SCAN=0, REQ_STATUS=1, REQ_ECHO=2, REQ_DEBUG=3.
  - Default ACK_TIMEOUT.
- One sub-module: rr_pick, purely combinational. Inputs req vector and start pointer; outputs found flag and index.

Test Plan:
- Single requester 0 sends frame {0x12, 0x35 last}; transmitter model drops tx_rdy 2 cycles after each strobe. Required: two data_wen low pulses carrying 0x12 then 0x35, two req_ready[0] pulses, rr_ptr=1 afterward.
- Requesters 1 and 2 both assert 2-byte frames in the same cycle from reset (rr_ptr=0). Required: owner 1's bytes both transmitted before any byte of owner 2, with grant_id=1 then 2.
- Requester 0 holds requests continuously while requester 3 requests once. Required: requester 3's frame is sent immediately after requester 0's current frame, with no second frame from 0 in between.
- Transmitter model never drops tx_rdy after a strobe with ACK_TIMEOUT=16. Required: timeout_err pulses exactly 16 cycles after the STROBE cycle, and the next byte proceeds.
- tx_rdy held low when requester 2 asserts. Required: no strobe and data_wen stays 1. Raise tx_rdy: strobe occurs on the next cycle.
- Assert rst_n low between bytes of a 3-byte frame. Required: data_wen=1, busy=0, req_ready=0 immediately. After release, a pending request is granted starting from rr_ptr=0.
